// File: rtl/bsg_cache_sbuf_ctl.sv
// Two-entry store buffer. Stores arrive from the tag-lookup stage and drain
// oldest-first to the data-array write port over a valid/yumi handshake. A
// combinational byte-wise bypass lets loads see every pending store,
// including a store that is arriving this cycle.
module bsg_cache_sbuf_ctl
  #(parameter int data_width_p = 32
  , parameter int addr_width_p = 32
  , localparam int data_mask_width_lp = data_width_p/8
  , localparam int word_offset_lp = $clog2(data_mask_width_lp)
  )
  (input  logic                          clk_i
  , input  logic                          reset_i

  , input  logic                          v_i
  , input  logic [addr_width_p-1:0]       addr_i
  , input  logic [data_width_p-1:0]       data_i
  , input  logic [data_mask_width_lp-1:0] mask_i
  , output logic                          ready_o

  , output logic                          v_o
  , output logic [addr_width_p-1:0]       addr_o
  , output logic [data_width_p-1:0]       data_o
  , output logic [data_mask_width_lp-1:0] mask_o
  , input  logic                          yumi_i

  , input  logic                          bypass_v_i
  , input  logic [addr_width_p-1:0]       bypass_addr_i
  , output logic [data_width_p-1:0]       bypass_data_o
  , output logic [data_mask_width_lp-1:0] bypass_mask_o

  , output logic                          empty_o
  , output logic                          full_o
  );

  // Only the count is reset; entry contents are qualified by the count.
  logic [1:0]                    count, count_n;
  logic [addr_width_p-1:0]       el0_addr, el1_addr;
  logic [data_width_p-1:0]       el0_data, el1_data;
  logic [data_mask_width_lp-1:0] el0_mask, el1_mask;

  logic enq, deq;
  logic el0_we, el0_from_el1, el1_we;

  assign empty_o = (count == 2'd0);
  assign full_o  = (count == 2'd2);
  assign v_o     = ~empty_o;
  // A dequeue frees a slot in the same cycle, so a full buffer can still
  // accept a store while it drains.
  assign ready_o = ~full_o | yumi_i;

  assign enq = v_i & ready_o;
  // yumi_i without a valid entry is a protocol error and is ignored here.
  assign deq = yumi_i & v_o;

  assign addr_o = el0_addr;
  assign data_o = el0_data;
  assign mask_o = el0_mask;

  // Next count and which entry registers load this cycle.
  always_comb begin
    count_n      = count;
    el0_we       = 1'b0;
    el0_from_el1 = 1'b0;
    el1_we       = 1'b0;
    case (count)
      2'd0: begin
        if (enq) begin
          el0_we  = 1'b1;
          count_n = 2'd1;
        end
      end
      2'd1: begin
        if (enq & deq) begin
          el0_we = 1'b1;
        end else if (enq) begin
          el1_we  = 1'b1;
          count_n = 2'd2;
        end else if (deq) begin
          count_n = 2'd0;
        end
      end
      2'd2: begin
        if (deq) begin
          el0_we       = 1'b1;
          el0_from_el1 = 1'b1;
          if (enq) el1_we = 1'b1;
          else     count_n = 2'd1;
        end
      end
      default: count_n = 2'd0;
    endcase
  end

  // Occupancy register; reset discards every pending store.
  always_ff @(posedge clk_i) begin
    if (reset_i) count <= 2'd0;
    else         count <= count_n;
  end

  // Entry 0 takes either the incoming store or the shifted-up entry 1.
  always_ff @(posedge clk_i) begin
    if (el0_we) begin
      el0_addr <= el0_from_el1 ? el1_addr : addr_i;
      el0_data <= el0_from_el1 ? el1_data : data_i;
      el0_mask <= el0_from_el1 ? el1_mask : mask_i;
    end
  end

  // Entry 1 only ever loads from the input.
  always_ff @(posedge clk_i) begin
    if (el1_we) begin
      el1_addr <= addr_i;
      el1_data <= data_i;
      el1_mask <= mask_i;
    end
  end

  // Word-granular address match against each bypass source. The registered
  // count is used, so a same-cycle dequeue still forwards entry 0.
  logic el0_match, el1_match, in_match;
  assign el0_match = (count != 2'd0)
    & (el0_addr[addr_width_p-1:word_offset_lp] == bypass_addr_i[addr_width_p-1:word_offset_lp]);
  assign el1_match = (count == 2'd2)
    & (el1_addr[addr_width_p-1:word_offset_lp] == bypass_addr_i[addr_width_p-1:word_offset_lp]);
  assign in_match  = v_i
    & (addr_i[addr_width_p-1:word_offset_lp] == bypass_addr_i[addr_width_p-1:word_offset_lp]);

  if (word_offset_lp > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = ^bypass_addr_i[word_offset_lp-1:0];
  end

  // Byte-wise merge, oldest to newest, so the newest supplier of a byte wins.
  always_comb begin
    bypass_data_o = '0;
    bypass_mask_o = '0;
    if (bypass_v_i) begin
      for (int b = 0; b < data_mask_width_lp; b++) begin
        if (el0_match & el0_mask[b]) begin
          bypass_data_o[8*b +: 8] = el0_data[8*b +: 8];
          bypass_mask_o[b]        = 1'b1;
        end
        if (el1_match & el1_mask[b]) begin
          bypass_data_o[8*b +: 8] = el1_data[8*b +: 8];
          bypass_mask_o[b]        = 1'b1;
        end
        if (in_match & mask_i[b]) begin
          bypass_data_o[8*b +: 8] = data_i[8*b +: 8];
          bypass_mask_o[b]        = 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Dequeue of an empty buffer is a consumer bug.
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_o));
  end
`endif

endmodule

// File: tb/tb_bsg_cache_sbuf_ctl.sv
// Bench for bsg_cache_sbuf_ctl: a reference queue tracks accepted stores and
// is compared against the head entry whenever the consumer dequeues.
module tb_bsg_cache_sbuf_ctl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  mask_i;
  logic        ready_o;
  logic        v_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  mask_o;
  logic        yumi_i;
  logic        bypass_v_i;
  logic [31:0] bypass_addr_i;
  logic [31:0] bypass_data_o;
  logic [3:0]  bypass_mask_o;
  logic        empty_o;
  logic        full_o;

  always #5 clk = ~clk;

  bsg_cache_sbuf_ctl #(.data_width_p(32), .addr_width_p(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i), .ready_o(ready_o),
    .v_o(v_o), .addr_o(addr_o), .data_o(data_o), .mask_o(mask_o), .yumi_i(yumi_i),
    .bypass_v_i(bypass_v_i), .bypass_addr_i(bypass_addr_i),
    .bypass_data_o(bypass_data_o), .bypass_mask_o(bypass_mask_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  st_t q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, check status and any dequeued entry, update the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic y);
    logic exp_ready;
    st_t  s;
    v_i = v; addr_i = a; data_i = d; mask_i = m; yumi_i = y;
    @(negedge clk);
    exp_ready = (q.size() != 2) || y;
    chk("ready", ready_o, exp_ready);
    chk("v_o", v_o, q.size() != 0);
    chk("empty", empty_o, q.size() == 0);
    chk("full", full_o, q.size() == 2);
    if (y && q.size() != 0) begin
      s = q.pop_front();
      chk("deq_addr", addr_o, s.a);
      chk("deq_data", data_o, s.d);
      chk("deq_mask", mask_o, s.m);
    end
    if (v && exp_ready) begin
      s.a = a; s.d = d; s.m = m;
      q.push_back(s);
    end
    @(posedge clk); #1;
    v_i = 1'b0; yumi_i = 1'b0;
  endtask

  task automatic drain();
    while (q.size() != 0) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0;
    yumi_i = 1'b0; bypass_v_i = 1'b0; bypass_addr_i = '0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    // Reset state
    bypass_v_i = 1'b1; bypass_addr_i = 32'h100;
    @(negedge clk);
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_bmask", bypass_mask_o, 4'h0);
    bypass_v_i = 1'b0;
    @(posedge clk); #1;

    // Single enqueue
    step(1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b0);
    chk("enq1_v_o", v_o, 1'b1);
    chk("enq1_addr", addr_o, 32'h100);
    chk("enq1_data", data_o, 32'hAABBCCDD);
    chk("enq1_empty", empty_o, 1'b0);
    drain();

    // Fill, stall the third store, then enqueue while dequeuing at full
    step(1'b1, 32'h100, 32'h01010101, 4'hF, 1'b0);
    step(1'b1, 32'h104, 32'h02020202, 4'hF, 1'b0);
    chk("fill_full", full_o, 1'b1);
    step(1'b1, 32'h108, 32'h03030303, 4'hF, 1'b0);
    step(1'b1, 32'h108, 32'h03030303, 4'hF, 1'b1);
    chk("shift_addr", addr_o, 32'h104);
    chk("shift_data", data_o, 32'h02020202);
    drain();

    // count=1 with simultaneous enqueue and dequeue
    step(1'b1, 32'h110, 32'h11111111, 4'hF, 1'b0);
    step(1'b1, 32'h114, 32'h22222222, 4'h3, 1'b1);
    chk("ed_full", full_o, 1'b0);
    chk("ed_data", data_o, 32'h22222222);
    drain();
    chk("drain_v_o", v_o, 1'b0);
    chk("drain_empty", empty_o, 1'b1);

    // Bypass merge across both entries
    step(1'b1, 32'h200, 32'h11223344, 4'hF, 1'b0);
    step(1'b1, 32'h202, 32'h55660000, 4'hC, 1'b0);
    bypass_v_i = 1'b1; bypass_addr_i = 32'h201;
    @(negedge clk);
    chk("bp_merge_data", bypass_data_o, 32'h55663344);
    chk("bp_merge_mask", bypass_mask_o, 4'hF);
    bypass_addr_i = 32'h204; #1;
    chk("bp_miss_mask", bypass_mask_o, 4'h0);
    chk("bp_miss_data", bypass_data_o, 32'h0);
    bypass_v_i = 1'b0; bypass_addr_i = 32'h200; #1;
    chk("bp_off_mask", bypass_mask_o, 4'h0);
    chk("bp_off_data", bypass_data_o, 32'h0);
    // Input store is forwarded even when the full buffer refuses it
    v_i = 1'b1; addr_i = 32'h200; data_i = 32'h000000AB; mask_i = 4'h1;
    bypass_v_i = 1'b1; #1;
    chk("bp_stall_data", bypass_data_o, 32'h556633AB);
    chk("bp_stall_ready", ready_o, 1'b0);
    v_i = 1'b0; bypass_v_i = 1'b0;
    @(posedge clk); #1;
    drain();

    // Bypass of the arriving store with an empty buffer
    v_i = 1'b1; addr_i = 32'h300; data_i = 32'h000000EE; mask_i = 4'h1;
    bypass_v_i = 1'b1; bypass_addr_i = 32'h300;
    @(negedge clk);
    chk("bp_in_mask", bypass_mask_o, 4'h1);
    chk("bp_in_data", bypass_data_o, 32'h000000EE);
    bypass_addr_i = 32'h304; #1;
    chk("bp_in_miss_mask", bypass_mask_o, 4'h0);
    chk("bp_in_miss_data", bypass_data_o, 32'h0);
    v_i = 1'b0; bypass_v_i = 1'b0;
    @(posedge clk); #1;

    // Arriving store overrides entry 0; a same-cycle dequeue keeps entry 0 visible
    step(1'b1, 32'h300, 32'hFFFFFFFF, 4'hF, 1'b0);
    v_i = 1'b1; addr_i = 32'h300; data_i = 32'h000000EE; mask_i = 4'h1;
    bypass_v_i = 1'b1; bypass_addr_i = 32'h302;
    @(negedge clk);
    chk("bp_new_data", bypass_data_o, 32'hFFFFFFEE);
    chk("bp_new_mask", bypass_mask_o, 4'hF);
    v_i = 1'b0; yumi_i = 1'b1; #1;
    chk("bp_deq_data", bypass_data_o, 32'hFFFFFFFF);
    yumi_i = 1'b0; bypass_v_i = 1'b0;
    @(posedge clk); #1;
    drain();

    // Reset while full with enqueue and dequeue both requested
    step(1'b1, 32'h200, 32'h12345678, 4'hF, 1'b0);
    step(1'b1, 32'h204, 32'h9ABCDEF0, 4'hF, 1'b0);
    reset_i = 1'b1; v_i = 1'b1; addr_i = 32'h208; data_i = 32'h0; mask_i = 4'hF; yumi_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    q.delete();
    bypass_v_i = 1'b1; bypass_addr_i = 32'h200;
    @(negedge clk);
    chk("mrst_v_o", v_o, 1'b0);
    chk("mrst_full", full_o, 1'b0);
    chk("mrst_empty", empty_o, 1'b1);
    chk("mrst_bmask", bypass_mask_o, 4'h0);
    bypass_addr_i = 32'h208; #1;
    chk("mrst_bmask2", bypass_mask_o, 4'h0);
    bypass_v_i = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the reference queue
    for (int i = 0; i < 300; i++) begin
      logic y;
      y = (q.size() != 0) && ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)), y);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bsg_cache_sbuf_ctl.md
Name: bsg_cache_sbuf_ctl

Overview:
- Two-entry store buffer with its own control: it accepts stores on the cache pipeline side and drains them oldest-first to the data-array write port over a valid/yumi handshake.
- Stores are held as addr, data and byte mask. Entry 0 is the oldest, entry 1 the newest.
- Provides a zero-latency byte-wise bypass so that loads see pending stores. The bypass merges both entries and the store arriving this cycle.
- Sits between the cache tag-lookup stage and the data-memory write arbiter.

Parameters:
- data_width_p, 32, store data width in bits; must be a multiple of 8.
- addr_width_p, 32, byte address width.
- data_mask_width_lp, data_width_p/8, derived; byte mask width.
- word_offset_lp, log2(data_mask_width_lp), derived; number of byte-offset bits ignored by the bypass compare.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  store valid.
- addr_i  in  addr_width_p  store byte address.
- data_i  in  data_width_p  store data.
- mask_i  in  data_mask_width_lp  store byte mask.
- ready_o  out  1  store is accepted this cycle when v_i & ready_o; ready_o = ~full_o | yumi_i.
- v_o  out  1  oldest entry valid.
- addr_o  out  addr_width_p  oldest entry address.
- data_o  out  data_width_p  oldest entry data.
- mask_o  out  data_mask_width_lp  oldest entry mask.
- yumi_i  in  1  consumer dequeues the oldest entry; legal only when v_o=1.
- bypass_v_i  in  1  bypass lookup request.
- bypass_addr_i  in  addr_width_p  lookup byte address.
- bypass_data_o  out  data_width_p  merged pending store data.
- bypass_mask_o  out  data_mask_width_lp  bytes supplied by pending stores.
- empty_o  out  1  count==0.
- full_o  out  1  count==2.

Behaviour:
- State is a 2-bit count (0, 1 or 2) plus entry0 and entry1 registers, each holding addr, data and mask.
- Reset: count=0, so v_o=0, empty_o=1, full_o=0 and ready_o=1. Entry contents are don't-care, but bypass_mask_o must be 0 while count=0 and v_i=0.
- Let enq = v_i & ready_o and deq = yumi_i & v_o.
- v_o = (count != 0). addr_o, data_o and mask_o always come from entry0.
- Transitions, with the new count registered at posedge:
  - count0, enq: entry0 <= input; count becomes 1.
  - count1, enq & ~deq: entry1 <= input; count becomes 2.
  - count1, deq & ~enq: count becomes 0.
  - count1, enq & deq: entry0 <= input; count stays 1.
  - count2, deq & ~enq: entry0 <= entry1; count becomes 1.
  - count2, enq & deq: entry0 <= entry1 and entry1 <= input; count stays 2.
  - count2, ~deq: v_i is not accepted (ready_o=0) and state holds.
- Latency:
  - A store enqueued in cycle t appears on v_o at t+1 at the earliest.
  - There is no combinational pass-through from v_i to v_o.
- Bypass is combinational, zero latency:
  - Match for a source = source valid & (source addr[addr_width_p-1:word_offset_lp] == bypass_addr_i[addr_width_p-1:word_offset_lp]).
  - Sources, oldest to newest: entry0 (valid if count>=1), entry1 (valid if count==2), input (valid if v_i; counted even when ready_o=0).
  - For each byte b, the newest matching source with mask[b]=1 supplies bypass_data_o byte b and sets bypass_mask_o[b]=1.
  - Bytes with no supplier have mask 0 and data 0.
  - When bypass_v_i=0, bypass_data_o=0 and bypass_mask_o=0.
  - A dequeue in the same cycle does not remove entry0 from the bypass result; the registered state is used.
- yumi_i while v_o=0 is a protocol error: it is ignored (no state change) and flagged by a simulation-only assertion.
- reset_i asserted mid-operation: all pending stores are discarded and count=0 on the next cycle, regardless of v_i or yumi_i.

Test Plan:
- Reset, then enqueue addr=0x100 data=0xAABBCCDD mask=0xF -> next cycle v_o=1, addr_o=0x100, data_o=0xAABBCCDD, count=1, empty_o=0.
- Enqueue 0x100, 0x104 and 0x108 with no yumi -> full_o=1 after two stores; ready_o=0 on the third; the third store is held off. Then assert yumi with v_i=1 -> next cycle data_o shows the 0x104 store and entry1 holds 0x108.
- count=1 with enq and deq in the same cycle -> count stays 1 and data_o equals the new store the next cycle. Drain to empty -> v_o=0, empty_o=1.
- Bypass merge: entry0 at 0x200 data=0x11223344 mask=0xF, entry1 at 0x202 data=0x55660000 mask=0xC, lookup 0x201 -> bypass_data_o=0x55663344, bypass_mask_o=0xF.
- Bypass including input: count=0, v_i=1 at 0x300 data=0x000000EE mask=0x1, lookup 0x300 -> bypass_mask_o=0x1, bypass_data_o=0x000000EE. Lookup 0x304 -> mask 0, data 0.
- With count=2, assert reset_i together with v_i=1 and yumi_i=1 -> next cycle count=0, v_o=0, full_o=0, and bypass_mask_o=0 for any address with v_i=0.
